// File: rtl/pc_fetch_gen.sv
// Fetch-PC owner: one fetch request in flight at a time, response held for decode
// behind a valid/ready handshake, trap/branch redirects kill stale fetches.
`timescale 1ns/1ps
module pc_fetch_gen #(
  parameter int              XLEN    = 64,
  parameter logic [XLEN-1:0] PC_INIT = 64'h0000_0000_8000_0000,
  parameter int              ISTEP   = 4,
  parameter int              ILEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic            i_br_valid,
  input  logic [XLEN-1:0] i_br_pc,
  output logic            o_ireq_valid,
  output logic [XLEN-1:0] o_ireq_addr,
  input  logic            i_ireq_ready,
  input  logic            i_iresp_valid,
  input  logic [ILEN-1:0] i_iresp_data,
  output logic            o_out_valid,
  output logic [XLEN-1:0] o_out_pc,
  output logic [ILEN-1:0] o_out_instr,
  output logic            o_out_misalign,
  input  logic            i_out_ready,
  output logic [1:0]      o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // ireq_addr is held while ireq_valid && !ireq_ready; out_* are held while
  // out_valid && !out_ready unless a redirect drops the instruction.

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] STEP       = XLEN'(ISTEP);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ISTEP - 1);

  state_t          r_state, w_state_nx;
  logic [XLEN-1:0] r_pc, w_pc_nx;
  logic [XLEN-1:0] r_req_addr, w_req_nx;
  logic [ILEN-1:0] r_instr, w_instr_nx;
  logic            r_misalign, w_mis_nx;
  logic            r_kill, w_kill_nx;

  logic            w_redir;
  logic [XLEN-1:0] w_target;
  logic            w_tgt_mis;

  assign w_redir   = i_trap_valid | i_br_valid;
  assign w_target  = i_trap_valid ? i_trap_pc : i_br_pc;
  assign w_tgt_mis = (w_target & ALIGN_MASK) != '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= PC_INIT;
      r_req_addr <= PC_INIT;
      r_instr    <= '0;
      r_misalign <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_req_addr <= w_req_nx;
      r_instr    <= w_instr_nx;
      r_misalign <= w_mis_nx;
      r_kill     <= w_kill_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_req_nx   = r_req_addr;
    w_instr_nx = r_instr;
    w_mis_nx   = r_misalign;
    w_kill_nx  = r_kill;
    case (r_state)
      S_REQ: begin
        // A stale request still goes out; kill marks its response for discard.
        if (i_ireq_ready) w_state_nx = S_WAIT;
        if (w_redir)      w_kill_nx  = 1'b1;
      end
      S_WAIT: begin
        if (i_iresp_valid) begin
          if (!r_kill && !w_redir) begin
            w_instr_nx = i_iresp_data;
            w_state_nx = S_HOLD;
          end else begin
            // r_pc already holds the redirect target when only kill is pending
            w_kill_nx = 1'b0;
            w_req_nx  = w_redir ? w_target : r_pc;
            if (w_redir ? w_tgt_mis : r_misalign) begin
              w_instr_nx = '0;
              w_state_nx = S_HOLD;
            end else begin
              w_state_nx = S_REQ;
            end
          end
        end else if (w_redir) begin
          w_kill_nx = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redir) begin
          w_req_nx = w_target;
          if (w_tgt_mis) w_instr_nx = '0;
          else           w_state_nx = S_REQ;
        end else if (!r_misalign && i_out_ready) begin
          w_pc_nx    = r_pc + STEP;
          w_req_nx   = r_pc + STEP;
          w_state_nx = S_REQ;
        end
      end
      default: w_state_nx = S_REQ;
    endcase
    if (w_redir) begin
      w_pc_nx  = w_target;
      w_mis_nx = w_tgt_mis;
    end
  end

  assign o_ireq_valid   = !reset && (r_state == S_REQ);
  assign o_ireq_addr    = r_req_addr;
  assign o_out_valid    = !reset && (r_state == S_HOLD) && !w_redir;
  assign o_out_pc       = r_pc;
  assign o_out_instr    = r_misalign ? '0 : r_instr;
  assign o_out_misalign = !reset && (r_state == S_HOLD) && r_misalign;
  assign o_dbg_state    = r_state;

endmodule
